// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states, opcodes,
// datapath mux selects and the DECODE routing helper.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // S_FETCH doubles as the "illegal instruction" marker.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_LUI:            decode_next = S_LUI;
      OP_BRANCH:         decode_next = (f3 == 3'b000 || f3 == 3'b001) ? S_BRANCH : S_FETCH;
      OP_JAL:            decode_next = S_JAL;
      OP_JALR:           decode_next = S_JALR;
      default:           decode_next = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7 to ALU operation for register and immediate arithmetic.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      3'b010:  alu_ctrl = ALU_SLT;
      // only R-type (opb5) can mean sub; addi with imm bit 10 set stays add
      3'b000:  alu_ctrl = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle RV32 control FSM with a bounded memory handshake; outputs are
// decoded from the state plus the memory/branch status inputs.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        EQ,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output logic [2:0]  ImmSrc,
  output logic [2:0]  ALUctrl,
  output logic [1:0]  Resultsrc,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(MEM_TIMEOUT);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [6:0]    op;
  logic [2:0]    f3;
  logic [2:0]    alu_fn;
  logic          mem_state, to_c, req_c, ack;
  logic          unused_instr;

  assign op           = Instr[6:0];
  assign f3           = Instr[14:12];
  assign unused_instr = &{1'b0, Instr[31], Instr[29:15], Instr[11:7]};

  alu_decoder u_alu_dec (
    .funct3   (f3),
    .funct7b5 (Instr[30]),
    .opb5     (Instr[5]),
    .alu_ctrl (alu_fn)
  );

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // the timeout cycle itself drops the request, so a late ready is ignored
  assign to_c  = (MEM_TIMEOUT > 0) && mem_state && (wait_cnt == TO_LIM);
  assign req_c = mem_state && !to_c;
  assign ack   = req_c && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH:    if (to_c) state <= S_FETCH; else if (ack) state <= S_DECODE;
        S_DECODE:   state <= decode_next(op, f3);
        S_MEMADR:   state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (to_c) state <= S_FETCH; else if (ack) state <= S_MEMWB;
        S_MEMWRITE: if (to_c || ack) state <= S_FETCH;
        S_EXECR, S_EXECI, S_LUI, S_JAL, S_LINK: state <= S_ALUWB;
        S_JALR:     state <= S_LINK;
        default:    state <= S_FETCH;
      endcase
      // every exit from a memory state clears, so each entry starts from zero
      if (to_c || ack)
        wait_cnt <= '0;
      else if (req_c && !mem_ready)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUsrcA    = SRCA_PC;
    ALUsrcB    = SRCB_RS2;
    ImmSrc     = IMM_I;
    ALUctrl    = ALU_ADD;
    Resultsrc  = RES_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = req_c;
          bus_err = to_c;
          if (ack) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUsrcB   = SRCB_FOUR;
            Resultsrc = RES_ALU;
          end
        end
        S_DECODE: begin
          ALUsrcA = SRCA_OLDPC;
          ALUsrcB = SRCB_IMM;
          ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
          illegal = (decode_next(op, f3) == S_FETCH);
        end
        S_MEMADR: begin
          ALUsrcA = SRCA_RS1;
          ALUsrcB = SRCB_IMM;
          ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = req_c;
          AdrSrc  = req_c;
          bus_err = to_c;
        end
        S_MEMWB: begin
          Resultsrc  = RES_RDATA;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = req_c;
          AdrSrc     = req_c;
          MemWrite   = req_c;
          instr_done = ack;
          bus_err    = to_c;
        end
        S_EXECR: begin
          ALUsrcA = SRCA_RS1;
          ALUctrl = alu_fn;
        end
        S_EXECI: begin
          ALUsrcA = SRCA_RS1;
          ALUsrcB = SRCB_IMM;
          ALUctrl = alu_fn;
        end
        S_LUI: begin
          ALUsrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
          ALUctrl = ALU_PASSB;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUsrcA    = SRCA_RS1;
          ALUctrl    = ALU_SUB;
          PCWrite    = ((f3 == 3'b000) && EQ) || ((f3 == 3'b001) && !EQ);
          instr_done = 1'b1;
        end
        S_JAL: begin
          PCWrite = 1'b1;
          ALUsrcA = SRCA_OLDPC;
          ALUsrcB = SRCB_FOUR;
        end
        S_JALR: begin
          ALUsrcA   = SRCA_RS1;
          ALUsrcB   = SRCB_IMM;
          Resultsrc = RES_ALU;
          PCWrite   = 1'b1;
        end
        S_LINK: begin
          ALUsrcA = SRCA_OLDPC;
          ALUsrcB = SRCB_FOUR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed per-cycle vectors for mc_control (MEM_TIMEOUT=4) plus a hand-written
// FETCH timeout sequence.
module tb_mc_control;

  logic        clk = 1'b0, rst = 1'b1, EQ = 1'b0, mem_ready = 1'b0;
  logic [31:0] Instr = '0;
  logic        mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [1:0]  ALUsrcA, ALUsrcB, Resultsrc;
  logic [2:0]  ImmSrc, ALUctrl;
  logic        instr_done, illegal, bus_err;

  always #5 clk = ~clk;

  mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .Resultsrc(Resultsrc),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        eq;
    logic        rdy;
    logic [20:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int checks = 0, failures = 0;

  // field order: req adr irw pcw rw mw srcA srcB imm alu res done ill berr
  function automatic logic [20:0] o(input logic req, adr, irw, pcw, rw, mw,
                                    input logic [1:0] a, b, input logic [2:0] imm, alu,
                                    input logic [1:0] res, input logic done, ill, berr);
    return {req, adr, irw, pcw, rw, mw, a, b, imm, alu, res, done, ill, berr};
  endfunction

  function automatic logic [20:0] exr(input logic [2:0] alu);
    return o(0,0,0,0,0,0, 2'b10,2'b00,3'b000,alu,2'b00, 0,0,0);
  endfunction
  function automatic logic [20:0] exi(input logic [2:0] alu);
    return o(0,0,0,0,0,0, 2'b10,2'b01,3'b000,alu,2'b00, 0,0,0);
  endfunction
  function automatic logic [20:0] br(input logic p);
    return o(0,0,0,p,0,0, 2'b10,2'b00,3'b000,3'b001,2'b00, 1,0,0);
  endfunction

  logic [20:0] RST0, F_W, F_R, DEC_B, DEC_J, DEC_ILL, MADR_L, MADR_S, MRD, MWB;
  logic [20:0] MWR, MWR_D, BERR, LUI_E, AWB, JAL_E, JALR_E, LINK_E;

  task automatic row(input logic r, input logic [31:0] ins, input logic e, rd,
                     input logic [20:0] x, input string nm);
    vec_t v;
    v.rst = r; v.instr = ins; v.eq = e; v.rdy = rd; v.exp = x; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [31:0] ins, input logic e, rd,
                      input logic [20:0] x, input string nm);
    logic [20:0] act;
    @(posedge clk);
    #1;
    rst = r; Instr = ins; EQ = e; mem_ready = rd;
    @(negedge clk);
    act = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUsrcA, ALUsrcB,
           ImmSrc, ALUctrl, Resultsrc, instr_done, illegal, bus_err};
    checks++;
    if (act !== x) begin
      failures++;
      $display("FAIL %s: got %06h want %06h", nm, act, x);
    end
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_SUB = 32'h402081B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3, I_AND = 32'h0020F1B3;
  localparam logic [31:0] I_ORI  = 32'h0050E193, I_ADDI30 = 32'h40008093;
  localparam logic [31:0] I_LW   = 32'h0000A283, I_SW = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063, I_BNE = 32'h00209063;
  localparam logic [31:0] I_BLT  = 32'h0020C063, I_ILL = 32'h0000007F;
  localparam logic [31:0] I_JAL  = 32'h000000EF, I_JALR = 32'h000100E7;
  localparam logic [31:0] I_LUI  = 32'h123452B7;

  initial begin
    RST0    = '0;
    F_W     = o(1,0,0,0,0,0, 2'b00,2'b00,3'b000,3'b000,2'b00, 0,0,0);
    F_R     = o(1,0,1,1,0,0, 2'b00,2'b10,3'b000,3'b000,2'b10, 0,0,0);
    DEC_B   = o(0,0,0,0,0,0, 2'b01,2'b01,3'b010,3'b000,2'b00, 0,0,0);
    DEC_J   = o(0,0,0,0,0,0, 2'b01,2'b01,3'b011,3'b000,2'b00, 0,0,0);
    DEC_ILL = o(0,0,0,0,0,0, 2'b01,2'b01,3'b010,3'b000,2'b00, 0,1,0);
    MADR_L  = o(0,0,0,0,0,0, 2'b10,2'b01,3'b000,3'b000,2'b00, 0,0,0);
    MADR_S  = o(0,0,0,0,0,0, 2'b10,2'b01,3'b001,3'b000,2'b00, 0,0,0);
    MRD     = o(1,1,0,0,0,0, 2'b00,2'b00,3'b000,3'b000,2'b00, 0,0,0);
    MWB     = o(0,0,0,0,1,0, 2'b00,2'b00,3'b000,3'b000,2'b01, 1,0,0);
    MWR     = o(1,1,0,0,0,1, 2'b00,2'b00,3'b000,3'b000,2'b00, 0,0,0);
    MWR_D   = o(1,1,0,0,0,1, 2'b00,2'b00,3'b000,3'b000,2'b00, 1,0,0);
    BERR    = o(0,0,0,0,0,0, 2'b00,2'b00,3'b000,3'b000,2'b00, 0,0,1);
    LUI_E   = o(0,0,0,0,0,0, 2'b00,2'b01,3'b100,3'b111,2'b00, 0,0,0);
    AWB     = o(0,0,0,0,1,0, 2'b00,2'b00,3'b000,3'b000,2'b00, 1,0,0);
    JAL_E   = o(0,0,0,1,0,0, 2'b01,2'b10,3'b000,3'b000,2'b00, 0,0,0);
    JALR_E  = o(0,0,0,1,0,0, 2'b10,2'b01,3'b000,3'b000,2'b10, 0,0,0);
    LINK_E  = o(0,0,0,0,0,0, 2'b01,2'b10,3'b000,3'b000,2'b00, 0,0,0);

    row(1, 0, 0, 1, RST0, "reset0");
    row(1, 0, 0, 1, RST0, "reset1");
    // add: 4 cycles
    row(0, I_ADD, 0, 1, F_R, "add_fetch");
    row(0, I_ADD, 0, 1, DEC_B, "add_decode");
    row(0, I_ADD, 0, 1, exr(3'b000), "add_execr");
    row(0, I_ADD, 0, 1, AWB, "add_aluwb");
    // lw with 3 wait cycles: 8 cycles total
    row(0, I_LW, 0, 1, F_R, "lw_fetch");
    row(0, I_LW, 0, 0, DEC_B, "lw_decode");
    row(0, I_LW, 0, 1, MADR_L, "lw_memadr");
    row(0, I_LW, 0, 0, MRD, "lw_rd_w1");
    row(0, I_LW, 0, 0, MRD, "lw_rd_w2");
    row(0, I_LW, 0, 0, MRD, "lw_rd_w3");
    row(0, I_LW, 0, 1, MRD, "lw_rd_ack");
    row(0, I_LW, 0, 0, MWB, "lw_memwb");
    // branches
    row(0, I_BEQ, 1, 1, F_R, "beq1_fetch");
    row(0, I_BEQ, 1, 0, DEC_B, "beq1_decode");
    row(0, I_BEQ, 1, 0, br(1), "beq1_taken");
    row(0, I_BEQ, 0, 1, F_R, "beq0_fetch");
    row(0, I_BEQ, 0, 0, DEC_B, "beq0_decode");
    row(0, I_BEQ, 0, 0, br(0), "beq0_nottaken");
    row(0, I_BNE, 0, 1, F_R, "bne0_fetch");
    row(0, I_BNE, 0, 0, DEC_B, "bne0_decode");
    row(0, I_BNE, 0, 0, br(1), "bne0_taken");
    row(0, I_BNE, 1, 1, F_R, "bne1_fetch");
    row(0, I_BNE, 1, 0, DEC_B, "bne1_decode");
    row(0, I_BNE, 1, 0, br(0), "bne1_nottaken");
    // jalr: 5 cycles
    row(0, I_JALR, 0, 1, F_R, "jalr_fetch");
    row(0, I_JALR, 0, 1, DEC_B, "jalr_decode");
    row(0, I_JALR, 0, 1, JALR_E, "jalr_jalr");
    row(0, I_JALR, 0, 1, LINK_E, "jalr_link");
    row(0, I_JALR, 0, 1, AWB, "jalr_aluwb");
    // jal, lui, other ALU ops
    row(0, I_JAL, 0, 1, F_R, "jal_fetch");
    row(0, I_JAL, 0, 1, DEC_J, "jal_decode");
    row(0, I_JAL, 0, 1, JAL_E, "jal_jal");
    row(0, I_JAL, 0, 1, AWB, "jal_aluwb");
    row(0, I_LUI, 0, 1, F_R, "lui_fetch");
    row(0, I_LUI, 0, 1, DEC_B, "lui_decode");
    row(0, I_LUI, 0, 1, LUI_E, "lui_lui");
    row(0, I_LUI, 0, 1, AWB, "lui_aluwb");
    row(0, I_SUB, 0, 1, F_R, "sub_fetch");
    row(0, I_SUB, 0, 1, DEC_B, "sub_decode");
    row(0, I_SUB, 0, 1, exr(3'b001), "sub_execr");
    row(0, I_SUB, 0, 1, AWB, "sub_aluwb");
    row(0, I_SLT, 0, 1, F_R, "slt_fetch");
    row(0, I_SLT, 0, 1, DEC_B, "slt_decode");
    row(0, I_SLT, 0, 1, exr(3'b101), "slt_execr");
    row(0, I_SLT, 0, 1, AWB, "slt_aluwb");
    row(0, I_AND, 0, 1, F_R, "and_fetch");
    row(0, I_AND, 0, 1, DEC_B, "and_decode");
    row(0, I_AND, 0, 1, exr(3'b010), "and_execr");
    row(0, I_AND, 0, 1, AWB, "and_aluwb");
    row(0, I_ORI, 0, 1, F_R, "ori_fetch");
    row(0, I_ORI, 0, 1, DEC_B, "ori_decode");
    row(0, I_ORI, 0, 1, exi(3'b011), "ori_execi");
    row(0, I_ORI, 0, 1, AWB, "ori_aluwb");
    row(0, I_ADDI30, 0, 1, F_R, "addi30_fetch");
    row(0, I_ADDI30, 0, 1, DEC_B, "addi30_decode");
    row(0, I_ADDI30, 0, 1, exi(3'b000), "addi30_execi_add");
    row(0, I_ADDI30, 0, 1, AWB, "addi30_aluwb");
    // sw with one wait cycle
    row(0, I_SW, 0, 1, F_R, "sw_fetch");
    row(0, I_SW, 0, 1, DEC_B, "sw_decode");
    row(0, I_SW, 0, 1, MADR_S, "sw_memadr");
    row(0, I_SW, 0, 0, MWR, "sw_wr_w1");
    row(0, I_SW, 0, 1, MWR_D, "sw_wr_ack");
    row(0, I_SW, 0, 0, F_W, "sw_next_fetch");
    // illegal opcodes
    row(0, I_ILL, 0, 1, F_R, "ill7f_fetch");
    row(0, I_ILL, 0, 1, DEC_ILL, "ill7f_decode");
    row(0, I_ILL, 0, 0, F_W, "ill7f_back_fetch");
    row(0, I_BLT, 1, 1, F_R, "blt_fetch");
    row(0, I_BLT, 1, 1, DEC_ILL, "blt_decode_ill");
    row(0, I_BLT, 1, 0, F_W, "blt_back_fetch");
    // sw timeout: 4 wait cycles then bus_err with MemWrite dropped
    row(0, I_SW, 0, 1, F_R, "swto_fetch");
    row(0, I_SW, 0, 0, DEC_B, "swto_decode");
    row(0, I_SW, 0, 0, MADR_S, "swto_memadr");
    row(0, I_SW, 0, 0, MWR, "swto_w1");
    row(0, I_SW, 0, 0, MWR, "swto_w2");
    row(0, I_SW, 0, 0, MWR, "swto_w3");
    row(0, I_SW, 0, 0, MWR, "swto_w4");
    row(0, I_SW, 0, 0, BERR, "swto_buserr");
    row(0, I_SW, 0, 0, F_W, "swto_next_fetch");
    // lw timeout: no RegWrite, no MEMWB
    row(0, I_LW, 0, 1, F_R, "lwto_fetch");
    row(0, I_LW, 0, 0, DEC_B, "lwto_decode");
    row(0, I_LW, 0, 0, MADR_L, "lwto_memadr");
    row(0, I_LW, 0, 0, MRD, "lwto_w1");
    row(0, I_LW, 0, 0, MRD, "lwto_w2");
    row(0, I_LW, 0, 0, MRD, "lwto_w3");
    row(0, I_LW, 0, 0, MRD, "lwto_w4");
    row(0, I_LW, 0, 0, BERR, "lwto_buserr");
    row(0, I_LW, 0, 0, F_W, "lwto_next_fetch");
    // reset while MEMREAD is waiting
    row(0, I_LW, 0, 1, F_R, "lwrst_fetch");
    row(0, I_LW, 0, 0, DEC_B, "lwrst_decode");
    row(0, I_LW, 0, 0, MADR_L, "lwrst_memadr");
    row(0, I_LW, 0, 0, MRD, "lwrst_rd_w1");
    row(1, I_LW, 0, 1, RST0, "lwrst_rst_a");
    row(1, I_LW, 0, 1, RST0, "lwrst_rst_b");
    row(0, I_LW, 0, 0, F_W, "lwrst_first_fetch");

    foreach (tbl[i]) step(tbl[i].rst, tbl[i].instr, tbl[i].eq, tbl[i].rdy, tbl[i].exp, tbl[i].name);

    // FETCH timeout: re-enters FETCH with a fresh count; ready during the
    // bus_err cycle is ignored, so the second round times out identically.
    step(1, I_ADD, 0, 0, RST0, "fto_reset");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) step(0, I_ADD, 0, 0, F_W, $sformatf("fto_r%0d_w%0d", r, k));
      step(0, I_ADD, 0, 1, BERR, $sformatf("fto_r%0d_buserr", r));
    end
    step(0, I_ADD, 0, 1, F_R, "fto_recover_fetch");
    step(0, I_ADD, 0, 1, DEC_B, "fto_recover_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
